sap_controller_sequencer: RTL

Control unit for the SAP-1 datapath. It sits directly downstream of the instruction register and consumes that register's 4-bit opcode field. A 6-state ring counter (T1..T6) is combined with the opcode to drive the one-bit load/enable lines of the PC, MAR, RAM, IR, A, B, ALU and output registers. The block supports halt and single-step operation.

---
 rtl/sap_controller_sequencer_if.sv | 38 +++
 rtl/sap_controller_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/sap_controller_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : sap_controller_sequencer_if
// Brief    : Opcode/step inputs and control-word outputs of the SAP-1 sequencer
// Revision : 1.0 - initial release
// ============================================================================
interface sap_controller_sequencer_if;
  logic [3:0] opcode;
  logic       step_mode;
  logic       step;
  logic [5:0] t_state;
  logic       halted;
  logic       pc_inc;
  logic       pc_out;
  logic       mar_in;
  logic       ram_out;
  logic       ir_in;
  logic       ir_out;
  logic       a_in;
  logic       a_out;
  logic       b_in;
  logic       alu_out;
  logic       alu_sub;
  logic       out_in;

  modport master (
    input  opcode, step_mode, step,
    output t_state, halted, pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out,
           a_in, a_out, b_in, alu_out, alu_sub, out_in
  );

  modport slave (
    output opcode, step_mode, step,
    input  t_state, halted, pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out,
           a_in, a_out, b_in, alu_out, alu_sub, out_in
  );
endinterface
`default_nettype wire

// File: rtl/sap_controller_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sap_controller_sequencer
// Brief    : SAP-1 control unit: T1..T6 ring counter decoded with the opcode
// Revision : 1.0 - initial release
// ============================================================================
module sap_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  sap_controller_sequencer_if.master bus
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e r_t;
  logic     r_halted;
  logic     r_step_d;
  logic     w_advance;

  // In step mode only the rising edge of the level step counts.
  assign w_advance = bus.step_mode ? (bus.step & ~r_step_d) : 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_t      <= T1;
      r_halted <= 1'b0;
      r_step_d <= 1'b0;
    end else begin
      r_step_d <= bus.step;
      if (w_advance && !r_halted) begin
        if (r_t == T4 && bus.opcode == OP_HLT) begin
          r_halted <= 1'b1;
        end else begin
          case (r_t)
            T1:      r_t <= T2;
            T2:      r_t <= T3;
            T3:      r_t <= T4;
            T4:      r_t <= T5;
            T5:      r_t <= T6;
            default: r_t <= T1;
          endcase
        end
      end
    end
  end

  assign bus.t_state = r_t;
  assign bus.halted  = r_halted;

  // Fetch states ignore the opcode: IR is not valid until T3 has closed.
  always_comb begin
    bus.pc_inc  = 1'b0;
    bus.pc_out  = 1'b0;
    bus.mar_in  = 1'b0;
    bus.ram_out = 1'b0;
    bus.ir_in   = 1'b0;
    bus.ir_out  = 1'b0;
    bus.a_in    = 1'b0;
    bus.a_out   = 1'b0;
    bus.b_in    = 1'b0;
    bus.alu_out = 1'b0;
    bus.alu_sub = 1'b0;
    bus.out_in  = 1'b0;
    if (!r_halted) begin
      case (r_t)
        T1: begin
          bus.pc_out = 1'b1;
          bus.mar_in = 1'b1;
        end
        T2: bus.pc_inc = 1'b1;
        T3: begin
          bus.ram_out = 1'b1;
          bus.ir_in   = 1'b1;
        end
        T4: begin
          if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            bus.ir_out = 1'b1;
            bus.mar_in = 1'b1;
          end else if (bus.opcode == OP_OUT) begin
            bus.a_out  = 1'b1;
            bus.out_in = 1'b1;
          end
        end
        T5: begin
          if (bus.opcode == OP_LDA) begin
            bus.ram_out = 1'b1;
            bus.a_in    = 1'b1;
          end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            bus.ram_out = 1'b1;
            bus.b_in    = 1'b1;
          end
        end
        T6: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            bus.alu_out = 1'b1;
            bus.a_in    = 1'b1;
            bus.alu_sub = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
